pll_reconf_sequencer: RTL and testbench

Parametrised successor to the single-option PLL reconfiguration kick-off logic. It debounces a requested PLL option and issues a one-cycle SSTEP pulse with a stable STATE word to the PLL DRP reconfiguration core. It then waits for SRDY, with a timeout, bounded retries and queuing of a request that arrives mid-operation. It sits between the core's PLL option register and the DRP wrapper, in the same clock domain as the DRP.

---
 rtl/pll_reconf_pkg.sv | 21 ++
 rtl/pll_reconf_timer.sv | 28 ++
 rtl/pll_reconf_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_pll_reconf_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reconf_pkg.sv
// Shared types and defaults for the PLL reconfiguration sequencer.
package pll_reconf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STEP,
    WAIT_RDY,
    ERROR
  } state_e;

  localparam int unsigned DEF_SETTLE_CYCLES  = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 65535;
  localparam int unsigned DEF_MAX_RETRY      = 2;

  // Bits needed to hold the values 0..n, never less than one.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pll_reconf_timer.sv
// Loadable saturating down-counter with a zero flag.
module pll_reconf_timer #(
  parameter int unsigned    W       = 4,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= RST_VAL;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pll_reconf_sequencer.sv
// Debounces a PLL option request, pulses SSTEP to the DRP core and waits for
// SRDY with timeout, bounded retries and implicit queuing of a newer request.
module pll_reconf_sequencer
  import pll_reconf_pkg::*;
#(
  parameter int unsigned OPT_W          = 3,
  parameter int unsigned SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned MAX_RETRY      = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPT_W-1:0] option_req,
  input  logic             srdy,
  output logic             sstep,
  output logic [OPT_W-1:0] state_out,
  output logic [OPT_W-1:0] cur_option,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int unsigned SW = cnt_w(SETTLE_CYCLES);
  localparam int unsigned TW = cnt_w(TIMEOUT_CYCLES);
  localparam int unsigned RW = cnt_w(MAX_RETRY);

  localparam logic [SW-1:0] SETTLE_LOAD  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

  state_e           r_state;
  state_e           w_next;
  logic [OPT_W-1:0] r_target;
  logic [OPT_W-1:0] r_state_out;
  logic [OPT_W-1:0] r_cur_option;
  logic             r_boot_req;
  logic [RW-1:0]    r_retry;
  logic             r_done;
  logic             r_error;

  logic w_settle_load;
  logic w_settle_dec;
  logic w_settle_zero;
  logic w_tmo_load;
  logic w_tmo_dec;
  logic w_tmo_zero;

  pll_reconf_timer #(
    .W       (SW),
    .RST_VAL (SETTLE_LOAD)
  ) u_settle (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_settle_load),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (w_settle_dec),
    .o_zero     (w_settle_zero)
  );

  pll_reconf_timer #(
    .W       (TW),
    .RST_VAL ('0)
  ) u_timeout (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_load     (w_tmo_load),
    .i_load_val (TIMEOUT_LOAD),
    .i_dec      (w_tmo_dec),
    .o_zero     (w_tmo_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SETTLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next        = r_state;
    w_settle_load = 1'b0;
    w_settle_dec  = 1'b0;
    w_tmo_load    = 1'b0;
    w_tmo_dec     = 1'b0;
    case (r_state)
      IDLE: begin
        if ((option_req != r_cur_option) || r_boot_req) begin
          w_settle_load = 1'b1;
          w_next        = SETTLE;
        end
      end
      SETTLE: begin
        if (option_req != r_target) begin
          w_settle_load = 1'b1;
        end else if (w_settle_zero) begin
          w_next = STEP;
        end else begin
          w_settle_dec = 1'b1;
        end
      end
      STEP: begin
        w_tmo_load = 1'b1;
        w_next     = WAIT_RDY;
      end
      WAIT_RDY: begin
        // srdy takes priority over a simultaneous timeout expiry
        if (srdy) begin
          w_next = IDLE;
        end else if (w_tmo_zero) begin
          w_next = (r_retry < RETRY_MAX) ? STEP : ERROR;
        end else begin
          w_tmo_dec = 1'b1;
        end
      end
      ERROR: begin
        if (option_req != r_state_out) begin
          w_settle_load = 1'b1;
          w_next        = SETTLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target     <= '0;
      r_state_out  <= '0;
      r_cur_option <= '0;
      r_boot_req   <= 1'b1;
      r_retry      <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_next == SETTLE) begin
            r_target <= option_req;
          end
        end
        SETTLE: begin
          if (option_req != r_target) begin
            r_target <= option_req;
          end else if (w_settle_zero) begin
            r_state_out <= r_target;
          end
        end
        WAIT_RDY: begin
          if (srdy) begin
            r_cur_option <= r_state_out;
            r_boot_req   <= 1'b0;
            r_retry      <= '0;
            r_done       <= 1'b1;
          end else if (w_tmo_zero) begin
            if (r_retry < RETRY_MAX) begin
              r_retry <= r_retry + 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        ERROR: begin
          if (option_req != r_state_out) begin
            r_error  <= 1'b0;
            r_retry  <= '0;
            r_target <= option_req;
          end
        end
        default: ;
      endcase
    end
  end

  assign sstep      = (r_state == STEP);
  assign busy       = (r_state != IDLE) && (r_state != ERROR);
  assign state_out  = r_state_out;
  assign cur_option = r_cur_option;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_pll_reconf_sequencer.sv
// Directed bench for pll_reconf_sequencer; cycle k starts at a rising edge,
// outputs are checked and inputs driven on the falling edge of that cycle.
module tb_pll_reconf_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] option_req;
  logic       srdy;
  logic       sstep;
  logic [2:0] state_out;
  logic [2:0] cur_option;
  logic       busy;
  logic       done;
  logic       error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reconf_sequencer #(
    .OPT_W          (3),
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .option_req (option_req),
    .srdy       (srdy),
    .sstep      (sstep),
    .state_out  (state_out),
    .cur_option (cur_option),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  task automatic test_reset;
    rst = 1'b1; option_req = 3'd0; srdy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (sstep !== 1'b0) begin errors++; $display("FAIL rst_sstep got %b want 0", sstep); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL rst_state_out got %0d want 0", state_out); end
    checks++; if (cur_option !== 3'd0) begin errors++; $display("FAIL rst_cur_option got %0d want 0", cur_option); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL rst_error got %b want 0", error); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
  endtask

  task automatic test_boot;
    rst = 1'b0;
    for (int k = 2; k <= 21; k++) begin
      @(negedge clk);
      checks++; if (sstep !== (k == 9)) begin errors++; $display("FAIL boot_sstep k=%0d got %b want %b", k, sstep, (k == 9)); end
      if (k == 9) begin
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL boot_state_out got %0d want 0", state_out); end
      end
      if (k == 20) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL boot_done_early got %b want 0", done); end
      end
      if (k == 21) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL boot_done got %b want 1", done); end
        checks++; if (cur_option !== 3'd0) begin errors++; $display("FAIL boot_cur_option got %0d want 0", cur_option); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL boot_busy got %b want 0", busy); end
      end
      srdy = (k == 20);
    end
  endtask

  task automatic test_change;
    option_req = 3'd5;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++; if (sstep !== (k == 9)) begin errors++; $display("FAIL chg_sstep k=%0d got %b want %b", k, sstep, (k == 9)); end
      if (k == 9) begin
        checks++; if (state_out !== 3'd5) begin errors++; $display("FAIL chg_state_out got %0d want 5", state_out); end
      end
      if (k == 10 || k == 11) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL chg_srdy_in_step k=%0d done got %b want 0", k, done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL chg_busy k=%0d got %b want 1", k, busy); end
      end
      if (k == 12) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL chg_done got %b want 1", done); end
        checks++; if (cur_option !== 3'd5) begin errors++; $display("FAIL chg_cur_option got %0d want 5", cur_option); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chg_busy_end got %b want 0", busy); end
      end
      srdy = (k == 9) || (k == 11);
    end
  endtask

  task automatic test_debounce;
    option_req = 3'd2;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checks++; if (sstep !== (k == 13)) begin errors++; $display("FAIL deb_sstep k=%0d got %b want %b", k, sstep, (k == 13)); end
      if (k == 13) begin
        checks++; if (state_out !== 3'd6) begin errors++; $display("FAIL deb_state_out got %0d want 6", state_out); end
      end
      if (k == 4) option_req = 3'd6;
    end
  endtask

  task automatic test_queue;
    option_req = 3'd1;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++; if (sstep !== (k == 12)) begin errors++; $display("FAIL q_sstep k=%0d got %b want %b", k, sstep, (k == 12)); end
      if (k <= 3) begin
        checks++; if (state_out !== 3'd6) begin errors++; $display("FAIL q_state_out_held k=%0d got %0d want 6", k, state_out); end
      end
      if (k == 3) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL q_done got %b want 1", done); end
        checks++; if (cur_option !== 3'd6) begin errors++; $display("FAIL q_cur_option got %0d want 6", cur_option); end
      end
      if (k == 12) begin
        checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL q_state_out_next got %0d want 1", state_out); end
      end
      if (k == 15) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL q_done2 got %b want 1", done); end
        checks++; if (cur_option !== 3'd1) begin errors++; $display("FAIL q_cur_option2 got %0d want 1", cur_option); end
      end
      srdy = (k == 2) || (k == 14);
    end
  endtask

  task automatic test_timeout_retry;
    logic exp_step;
    option_req = 3'd3;
    for (int k = 1; k <= 73; k++) begin
      @(negedge clk);
      exp_step = (k == 9) || (k == 26) || (k == 43) || (k == 71);
      checks++; if (sstep !== exp_step) begin errors++; $display("FAIL tmo_sstep k=%0d got %b want %b", k, sstep, exp_step); end
      if (k == 9 || k == 26 || k == 43) begin
        checks++; if (state_out !== 3'd3) begin errors++; $display("FAIL tmo_state_out k=%0d got %0d want 3", k, state_out); end
      end
      if (k == 59) begin
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL tmo_error_early got %b want 0", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_early got %b want 1", busy); end
      end
      if (k == 60) begin
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL tmo_error got %b want 1", error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got %b want 0", busy); end
      end
      if (k == 62) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL err_srdy_done got %b want 0", done); end
        checks++; if (cur_option !== 3'd1) begin errors++; $display("FAIL err_cur_option got %0d want 1", cur_option); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", error); end
      end
      if (k == 63) begin
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", error); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL err_exit_busy got %b want 1", busy); end
      end
      if (k == 71) begin
        checks++; if (state_out !== 3'd4) begin errors++; $display("FAIL err_new_state_out got %0d want 4", state_out); end
      end
      srdy = (k == 61);
      if (k == 62) option_req = 3'd4;
    end
  endtask

  task automatic test_reset_wait;
    option_req = 3'd0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rw_busy got %b want 1", busy); end
    checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL rw_state_out got %0d want 0", state_out); end
    checks++; if (cur_option !== 3'd0) begin errors++; $display("FAIL rw_cur_option got %0d want 0", cur_option); end
    checks++; if (sstep !== 1'b0) begin errors++; $display("FAIL rw_sstep got %b want 0", sstep); end
    rst = 1'b0;
    srdy = 1'b1;
    for (int k = 2; k <= 12; k++) begin
      @(negedge clk);
      checks++; if (sstep !== (k == 9)) begin errors++; $display("FAIL rw_boot_sstep k=%0d got %b want %b", k, sstep, (k == 9)); end
      if (k == 2) begin
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rw_late_srdy_done got %b want 0", done); end
        checks++; if (cur_option !== 3'd0) begin errors++; $display("FAIL rw_late_cur_option got %0d want 0", cur_option); end
      end
      if (k == 12) begin
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rw_done got %b want 1", done); end
        checks++; if (cur_option !== 3'd0) begin errors++; $display("FAIL rw_cur_option_end got %0d want 0", cur_option); end
      end
      srdy = (k == 11);
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_change();
    test_debounce();
    test_queue();
    test_timeout_retry();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
